// File: rtl/hpdcache_gnt_fwd_pkg.sv
// Shared defaults and helpers for the grant-driven request forwarder.
package hpdcache_gnt_fwd_pkg;

    localparam int unsigned DEF_N = 2;
    localparam int unsigned DEF_W = 32;

    // A single requester still needs a 1-bit source field so widths never hit zero.
    function automatic int unsigned src_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpdcache_gnt_fwd_if.sv
// Request/grant/output bundle between the requesters, the arbiter and the forwarder.
interface hpdcache_gnt_fwd_if
    import hpdcache_gnt_fwd_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
);
    localparam int unsigned SW = src_width(N);

    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   gnt_i;
    logic           arb_ready_o;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [W-1:0]   out_data_o;
    logic [SW-1:0]  out_src_o;

    // The forwarder sits on the slave side: it consumes requests and grants.
    modport slave (
        input  req_valid_i, req_data_i, gnt_i, out_ready_i,
        output req_ready_o, arb_ready_o, out_valid_o, out_data_o, out_src_o
    );

    // Requesters, arbiter and downstream together form the master side.
    modport master (
        output req_valid_i, req_data_i, gnt_i, out_ready_i,
        input  req_ready_o, arb_ready_o, out_valid_o, out_data_o, out_src_o
    );

endinterface

// File: rtl/hpdcache_gnt_fwd_buf.sv
// Two-entry {data, src} FIFO; read side is a register mux so outputs have no input path.
module hpdcache_gnt_fwd_buf #(
    parameter int unsigned W  = 32,
    parameter int unsigned SW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    input  logic [SW-1:0] wsrc,
    output logic [W-1:0]  rdata,
    output logic [SW-1:0] rsrc,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  data_q [2];
    logic [SW-1:0] src_q  [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    // Storage, pointers and occupancy; reset clears entries so outputs read as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            src_q[0]  <= '0;
            src_q[1]  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= wdata;
                src_q[wr_ptr]  <= wsrc;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign rdata = data_q[rd_ptr];
    assign rsrc  = src_q[rd_ptr];

    count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= 2'd2);

endmodule

// File: rtl/hpdcache_gnt_fwd.sv
// Selects the granted requester's payload, buffers it with its index, and
// throttles the arbiter so the grant only advances on an accepted transfer.
module hpdcache_gnt_fwd
    import hpdcache_gnt_fwd_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input logic                clk_i,
    input logic                rst_ni,
    hpdcache_gnt_fwd_if.slave  bus
);

    localparam int unsigned SW = src_width(N);

    logic [W-1:0]  sel_data;
    logic [SW-1:0] sel_src;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // One-hot mux of the payload and one-hot-to-binary encode of the grant.
    always_comb begin
        sel_data = '0;
        sel_src  = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.gnt_i[k]) begin
                sel_data = sel_data | bus.req_data_i[k*W +: W];
                sel_src  = sel_src | SW'(k);
            end
        end
    end

    assign bus.arb_ready_o = ~full;
    assign bus.req_ready_o = bus.gnt_i & {N{~full}};
    assign push            = (|(bus.gnt_i & bus.req_valid_i)) & ~full;
    assign pop             = bus.out_valid_o & bus.out_ready_i;
    assign bus.out_valid_o = ~empty;

    hpdcache_gnt_fwd_buf #(
        .W  (W),
        .SW (SW)
    ) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .wdata  (sel_data),
        .wsrc   (sel_src),
        .rdata  (bus.out_data_o),
        .rsrc   (bus.out_src_o),
        .full   (full),
        .empty  (empty)
    );

    gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.gnt_i));

    gnt_needs_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.gnt_i & ~bus.req_valid_i) == '0);

    out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.out_valid_o && !bus.out_ready_i) |=>
            ($stable(bus.out_data_o) && $stable(bus.out_src_o)));

endmodule

// File: doc/hpdcache_gnt_fwd.md
# hpdcache_gnt_fwd

Grant-driven request forwarder that sits directly downstream of the cache's round-robin request arbiter. It takes the arbiter's one-hot grant vector and uses it to select one of N requester payloads. The selected payload goes into a 2-entry output buffer, and the block drives the arbiter's `ready_i` so the grant advances only when a transfer actually happens. It turns N valid/ready request ports plus an external arbiter into a single registered valid/ready stream tagged with the source index.

## Interface
- `N`, default 2: number of requesters; N ≥ 1.
- `W`, default 32: payload width in bits; W ≥ 1.
- `SW`, default `(N > 1) ? $clog2(N) : 1`: source index width; derived, not overridden.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_valid_i` in N: per-requester valid; also wired to the arbiter's `req_i`.
- `req_ready_o` out N: per-requester ready.
- `req_data_i` in N*W: flattened payloads; requester k occupies bits [k*W +: W].
- `gnt_i` in N: one-hot-or-zero grant from the arbiter.
- `arb_ready_o` out 1: drives the arbiter's `ready_i`.
- `out_valid_o` out 1: buffered request valid.
- `out_ready_i` in 1: downstream ready.
- `out_data_o` out W: buffered payload.
- `out_src_o` out SW: binary index of the requester that produced `out_data_o`.

## Operation
- Buffer state: two entries of {data W, src SW}, `wr_ptr` 1 bit, `rd_ptr` 1 bit, `count` 2 bits (0..2).
- `full = (count == 2)`.
- `arb_ready_o = ~full`.
- `req_ready_o = gnt_i & {N{~full}}`.
- Push = `|(gnt_i & req_valid_i) & ~full`.
  - On push, write the one-hot-muxed payload and the binary-encoded index of `gnt_i` at `wr_ptr`, then toggle `wr_ptr`.
- Pop = `out_valid_o & out_ready_i`; on pop, toggle `rd_ptr`.
- `out_valid_o = (count != 0)`.
- `out_data_o` and `out_src_o` come from the entry at `rd_ptr`. Both are registered outputs with no combinational path from any input.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Full with pop: no push that cycle, because `arb_ready_o` was already low. Count goes 2→1, and the arbiter holds its grant.
- Empty: pop is impossible. A push makes data visible the next cycle.
- `gnt_i == 0`: no push, even though `arb_ready_o` may be high.
- Pointers wrap modulo 2 without any special case.
- Reset (asynchronous, any time):
  - `count = 0`, `wr_ptr = 0`, `rd_ptr = 0`.
  - Entry data and src are 0.
  - Outputs: `out_valid_o = 0`, `out_data_o = 0`, `out_src_o = 0`, `arb_ready_o = 1`, `req_ready_o = gnt_i`.
- An in-flight entry is discarded on reset.
- Simulation-only checks:
  - `$onehot0(gnt_i)`.
  - `(gnt_i & ~req_valid_i) == 0`.
  - `count ≤ 2`.
  - `out_data_o` and `out_src_o` stable while `out_valid_o & ~out_ready_i`.

## Timing
- Latency: a requester handshake in cycle t gives `out_valid_o` with that payload in cycle t+1.
- Throughput: 1 request per cycle sustained when `out_ready_i` is held high. With one entry occupied and pop plus push every cycle, count stays at 1.
- `req_ready_o` and `arb_ready_o` depend only on `gnt_i` and registered `count`. There is no combinational path from `out_ready_i` to any upstream ready.
- The arbiter grant advances on the same edge as the push. Because `arb_ready_o` is high whenever a push is possible, grant and acceptance are consumed together.
- When full, a requester's valid and payload must be held until its `req_ready_o`. The arbiter holds its grant because `ready_i` is low.

## Structure
- Sub-module `hpdcache_gnt_fwd_buf`: the 2-entry {data, src} buffer with push/pop/full/empty. It is parameterized by W and SW.
- One-hot mux and one-hot-to-binary encoder are local always_comb loops. The payload is width-parameterized, so no package typedefs are needed. SW is a localparam derived from N.

## Test plan
- Single requester, N=4: `req_valid_i=4'b0100`, `gnt_i=4'b0100`, data 0xA5, `out_ready_i=1`.
  - Next cycle: `out_valid_o=1`, `out_data_o=0xA5`, `out_src_o=2`.
  - Following cycle: `out_valid_o=0`.
- Backpressure fill: `out_ready_i=0`, two grants pushed on consecutive cycles.
  - Then: `arb_ready_o=0`, `req_ready_o=0`, count=2.
  - Raising `out_ready_i` pops in order, and `arb_ready_o` returns to 1 the cycle after the first pop.
- Streaming, N=4: all requesters valid, grants rotate 0,1,2,3 every cycle, `out_ready_i=1`.
  - `out_src_o` sequence is 0,1,2,3, one per cycle.
  - count stays at 1 after the first push.
- Simultaneous push and pop at count=1: values 0x11 then 0x22.
  - count stays at 1 and the output order is 0x11, 0x22.
- Idle grant: `gnt_i=0` with `req_valid_i=0`.
  - No push, `out_valid_o` stays 0, `arb_ready_o=1`.
- Reset mid-operation: count=2, assert `rst_ni=0` asynchronously between edges.
  - Immediately: `out_valid_o=0`, `out_data_o=0`, `arb_ready_o=1`.
  - After release: the first push appears after 1 cycle.
